// File: rtl/debounce_multi.sv
// N-channel button debouncer with per-channel active-level selection, press/release
// edge pulses, and long-press / auto-repeat events driven by a per-channel hold FSM.
module debounce_multi #(
  parameter int              N_CH          = 4,
  parameter int              STABLE_CYCLES = 500000,
  parameter int              LONG_CYCLES   = 50000000,
  parameter int              REPEAT_CYCLES = 10000000,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] repeat_p
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LONG
  } hold_state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          s;
    logic          db;
    logic          flip;
    logic          rise;
    logic          fall;
    logic [SW-1:0] cnt;
    logic          press_q;
    logic          release_q;

    hold_state_e   state_q;
    hold_state_e   state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_d;
    logic          long_q;
    logic          long_d;
    logic          repeat_q;
    logic          repeat_d;

    assign s    = sync2 ^ ACTIVE_LOW[i];
    assign flip = (s != db) && (cnt == STABLE_LAST);
    assign rise = flip & s;
    assign fall = flip & ~s;

    // Synchronizer resets to the released pin level so active-low channels
    // idling high never look pressed while the pipeline refills after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1     <= ACTIVE_LOW[i];
        sync2     <= ACTIVE_LOW[i];
        cnt       <= '0;
        db        <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1     <= button_in[i];
        sync2     <= sync1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (s == db) begin
          cnt <= '0;
        end else if (cnt != STABLE_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          db        <= s;
          cnt       <= '0;
          press_q   <= s;
          release_q <= ~s;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        hold_q   <= '0;
        rep_q    <= '0;
        long_q   <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        hold_q   <= hold_d;
        rep_q    <= rep_d;
        long_q   <= long_d;
        repeat_q <= repeat_d;
      end
    end

    // A release decided on this edge wins over any long/repeat event due now.
    always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      rep_d    = rep_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == LONG_LAST) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (fall) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            rep_d   = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_q == REPEAT_LAST) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end

    assign db_out[i]    = db;
    assign press_p[i]   = press_q;
    assign release_p[i] = release_q;
    assign long_p[i]    = long_q;
    assign repeat_p[i]  = repeat_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: a window/arithmetic reference model predicts
// every cycle's outputs; a monitor pops predictions and compares them with the DUT.
module tb_debounce_multi;

  localparam int         N_CH   = 2;
  localparam int         STABLE = 8;
  localparam int         LONG   = 32;
  localparam int         REPEAT = 8;
  localparam logic [1:0] AL     = 2'b10;
  localparam int         MAXE   = 8192;

  logic       clk;
  logic       reset;
  logic [1:0] button_in;
  logic [1:0] db_out;
  logic [1:0] press_p;
  logic [1:0] release_p;
  logic [1:0] long_p;
  logic [1:0] repeat_p;

  debounce_multi #(
    .N_CH(N_CH),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REPEAT),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_in(button_in),
    .db_out(db_out),
    .press_p(press_p),
    .release_p(release_p),
    .long_p(long_p),
    .repeat_p(repeat_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int         e;
    logic [1:0] db;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    logic [1:0] rp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_num;

  // model state
  logic [1:0] pin_hist [0:MAXE-1];
  logic [1:0] s_hist   [0:MAXE-1];
  int         model_edge;
  logic [1:0] m_db;
  int         m_press_edge [2];

  // random stimulus state
  int   rem [2];
  logic lvl [2];

  always @(posedge clk or posedge reset) begin
    if (reset) edge_num <= 0;
    else       edge_num <= edge_num + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_num, act, expv);
    end
  endtask

  function automatic logic [31:0] dutOut();
    return {22'd0, db_out, press_p, release_p, long_p, repeat_p};
  endfunction

  task automatic modelReset();
    model_edge = 0;
    m_db = 2'b00;
    m_press_edge[0] = 0;
    m_press_edge[1] = 0;
  endtask

  // Predicts the outputs visible after the next edge, given the pins driven before it.
  // db flips when the last STABLE synchronized samples all disagree with it; long and
  // repeat come from the distance to the press edge.
  task automatic modelStep(input logic [1:0] pins);
    exp_t x;
    model_edge++;
    pin_hist[model_edge] = pins;
    x = '0;
    x.e = model_edge;
    for (int ch = 0; ch < 2; ch++) begin
      logic sv;
      logic all_diff;
      int   held;
      sv = (model_edge >= 3) ? (pin_hist[model_edge-2][ch] ^ AL[ch]) : 1'b0;
      s_hist[model_edge][ch] = sv;
      all_diff = 1'b1;
      for (int j = 0; j < STABLE; j++) begin
        logic sj;
        sj = (model_edge - j >= 1) ? s_hist[model_edge-j][ch] : 1'b0;
        if (sj == m_db[ch]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_db[ch] = ~m_db[ch];
        if (m_db[ch]) begin
          x.pr[ch] = 1'b1;
          m_press_edge[ch] = model_edge;
        end else begin
          x.rl[ch] = 1'b1;
        end
      end else if (m_db[ch]) begin
        held = model_edge - m_press_edge[ch];
        if (held == LONG) x.lg[ch] = 1'b1;
        else if (REPEAT > 0 && held > LONG && ((held - LONG) % REPEAT) == 0) x.rp[ch] = 1'b1;
      end
    end
    x.db = m_db;
    sb.push_back(x);
  endtask

  task automatic driveNow(input logic [1:0] pins);
    button_in = pins;
    modelStep(pins);
  endtask

  task automatic applyStimulus(input logic [1:0] pins, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      driveNow(pins);
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear asynchronously, then releases
  // it on a falling edge with the current pins fed to the freshly reset model.
  task automatic doReset(input int cycles);
    @(negedge clk);
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("reset_async", dutOut(), 32'd0);
    repeat (cycles) @(negedge clk);
    checkOutput("reset_held", dutOut(), 32'd0);
    reset = 1'b0;
    modelReset();
    driveNow(button_in);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (!reset && edge_num > 0 && sb.size() > 0) begin
      x = sb.pop_front();
      checkOutput("sb_align", edge_num, x.e);
      checkOutput("outputs", dutOut(), {22'd0, x.db, x.pr, x.rl, x.lg, x.rp});
    end
  end

  initial begin
    reset = 1'b1;
    button_in = 2'b10;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_state", dutOut(), 32'd0);
    reset = 1'b0;
    driveNow(2'b10);
    applyStimulus(2'b10, 40);

    // ch0 bounces every 3 clocks, then holds long enough for long + repeats
    for (int i = 0; i < 40; i++) begin
      applyStimulus({1'b1, ((i / 3) % 2 == 0) ? 1'b1 : 1'b0}, 1);
    end
    applyStimulus(2'b11, 80);
    applyStimulus(2'b10, 20);

    // short press, released before long
    applyStimulus(2'b11, 29);
    applyStimulus(2'b10, 30);

    // both channels pressed on the same clock (ch1 pin goes low)
    applyStimulus(2'b01, 50);
    applyStimulus(2'b10, 20);

    // reset in the middle of a hold, button kept pressed across it
    applyStimulus(2'b01, 25);
    doReset(3);
    applyStimulus(2'b01, 50);
    applyStimulus(2'b10, 20);

    rem[0] = 0;
    rem[1] = 0;
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      logic [1:0] pins;
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          case ($urandom_range(0, 3))
            0: begin lvl[ch] = ~lvl[ch]; rem[ch] = $urandom_range(1, 6); end
            1: begin lvl[ch] = 1'($urandom_range(0, 1)); rem[ch] = $urandom_range(8, 30); end
            2: begin lvl[ch] = 1'b1; rem[ch] = $urandom_range(40, 90); end
            default: begin lvl[ch] = 1'b0; rem[ch] = $urandom_range(10, 40); end
          endcase
        end
        rem[ch]--;
        pins[ch] = lvl[ch] ^ AL[ch];
      end
      applyStimulus(pins, 1);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
